// File: rtl/apb_master_fsm.sv
// APB initiator of the AHB-to-APB bridge: turns the pipelined AHB request stream into
// APB SETUP/ENABLE cycles and stalls the AHB side while an access is outstanding.
module apb_master_fsm #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Hclk,
  input  logic          Hresetn,
  input  logic          valid,
  input  logic          Hwrite,
  input  logic          Hwritereg,
  input  logic [AW-1:0] Haddr,
  input  logic [AW-1:0] Haddr1,
  input  logic [AW-1:0] Haddr2,
  input  logic [DW-1:0] Hwdata,
  input  logic [DW-1:0] Hwdata1,
  output logic [2:0]    Pselx,
  output logic          Penable,
  output logic          Pwrite,
  output logic [AW-1:0] Paddr,
  output logic [DW-1:0] Pwdata,
  output logic          Preadyout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  localparam logic [AW-1:0] SLV0_BASE = AW'(32'h8000_0000);
  localparam logic [AW-1:0] SLV1_BASE = AW'(32'h8400_0000);
  localparam logic [AW-1:0] SLV2_BASE = AW'(32'h8800_0000);
  localparam logic [AW-1:0] SLV_END   = AW'(32'h8C00_0000);

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  function automatic logic [2:0] slave_sel(input logic [AW-1:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= SLV0_BASE && addr < SLV1_BASE) begin
      sel = 3'b001;
    end else if (addr >= SLV1_BASE && addr < SLV2_BASE) begin
      sel = 3'b010;
    end else if (addr >= SLV2_BASE && addr < SLV_END) begin
      sel = 3'b100;
    end
    return sel;
  endfunction

  // A write launched from WWAIT is one pipeline stage younger than one launched
  // from WENABLEP, where the next write's data phase was stretched by the stall.
  always_comb begin
    wr_addr = Haddr2;
    wr_data = Hwdata1;
    if (state == ST_WWAIT) begin
      wr_addr = Haddr1;
      wr_data = Hwdata;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pselx     <= 3'b000;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Preadyout <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (valid && !Hwrite) begin
            state     <= ST_READ;
            Paddr     <= Haddr;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Pselx     <= slave_sel(Haddr);
            Preadyout <= 1'b0;
          end else begin
            state     <= valid ? ST_WWAIT : ST_IDLE;
            Pselx     <= 3'b000;
            Penable   <= 1'b0;
            Preadyout <= 1'b1;
          end
        end

        ST_READ: begin
          state     <= ST_RENABLE;
          Penable   <= 1'b1;
          Preadyout <= 1'b1;
        end

        ST_WRITE: begin
          state     <= valid ? ST_WENABLEP : ST_WENABLE;
          Penable   <= 1'b1;
          Preadyout <= 1'b1;
        end

        ST_WRITEP: begin
          state     <= ST_WENABLEP;
          Penable   <= 1'b1;
          Preadyout <= 1'b1;
        end

        ST_WWAIT, ST_WENABLEP: begin
          if (state == ST_WENABLEP && !Hwritereg) begin
            state     <= ST_READ;
            Paddr     <= Haddr;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Pselx     <= slave_sel(Haddr);
            Preadyout <= 1'b0;
          end else begin
            // A queued follow-on transfer keeps the AHB side stalled during SETUP.
            state     <= valid ? ST_WRITEP : ST_WRITE;
            Paddr     <= wr_addr;
            Pwdata    <= wr_data;
            Pwrite    <= 1'b1;
            Penable   <= 1'b0;
            Pselx     <= slave_sel(wr_addr);
            Preadyout <= !valid;
          end
        end

        default: begin
          state     <= ST_IDLE;
          Pselx     <= 3'b000;
          Penable   <= 1'b0;
          Preadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule
